// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared coordinate type, default 640x480@60 timing and total helpers
package vga_timing_pkg;
  typedef logic [9:0] coord_t;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam bit SYNC_POL_DEF  = 1'b0;
  function automatic int h_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction
  function automatic int v_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered blank/sync/frame decode; VGA_SYNC_DELAY_EN adds one register stage to hs, vs and frame_start
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_POL  = SYNC_POL_DEF
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output coord_t      DrawX,
  output coord_t      DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);
  localparam int H_TOTAL  = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL  = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must lie in 1..1024");
  end

  coord_t w_nx;
  coord_t w_ny;
  logic   w_blank;
  logic   w_hs;
  logic   w_vs;
  logic   w_fs;
  logic   r_hs;
  logic   r_vs;
  logic   r_fs;

  // next raster position; outputs decode from it so they line up with DrawX/DrawY
  always_comb begin
    w_nx    = (DrawX == H_LAST) ? '0 : DrawX + 10'd1;
    w_ny    = (DrawX != H_LAST) ? DrawY : (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
    w_blank = int'(w_nx) < H_VISIBLE && int'(w_ny) < V_VISIBLE;
    w_hs    = (int'(w_nx) >= HS_START && int'(w_nx) < HS_END) ? SYNC_POL : ~SYNC_POL;
    w_vs    = (int'(w_ny) >= VS_START && int'(w_ny) < VS_END) ? SYNC_POL : ~SYNC_POL;
    w_fs    = w_nx == '0 && w_ny == '0;
  end

  // counters, blank, frame counter and undelayed sync/frame registers
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      frame_count <= '0;
      r_hs        <= ~SYNC_POL;
      r_vs        <= ~SYNC_POL;
      r_fs        <= 1'b0;
    end else begin
      DrawX       <= w_nx;
      DrawY       <= w_ny;
      blank       <= w_blank;
      frame_count <= w_fs ? frame_count + 16'd1 : frame_count;
      r_hs        <= w_hs;
      r_vs        <= w_vs;
      r_fs        <= w_fs;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // extra stage so syncs match renderers that register RGB one cycle late
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      hs          <= r_hs;
      vs          <= r_vs;
      frame_start <= r_fs;
    end
  end
`else
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign frame_start = r_fs;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: closed-form raster model checked against default, small active-high and 1x1 instances
module tb_vga_timing_gen;
`ifdef VGA_SYNC_DELAY_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  typedef struct {
    int hv, hf, hsw, hb, vv, vf, vsw, vb;
    bit pol;
  } timing_t;

  typedef struct {
    int x, y, fc;
    bit b, hs, vs, fs;
  } exp_t;

  timing_t c_def   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
  timing_t c_small = '{4, 1, 1, 1, 2, 1, 1, 1, 1'b1};
  timing_t c_tiny  = '{1, 0, 0, 0, 1, 0, 0, 0, 1'b0};

  int errors = 0;
  int checks = 0;
  int t_def = 0, t_s = 0, t_t = 0;

  logic clk = 1'b0;
  logic rst_def = 1'b0, rst_s = 1'b0, rst_t = 1'b0;

  logic [9:0]  dx_d, dy_d, dx_s, dy_s, dx_t, dy_t;
  logic        bl_d, hs_d, vs_d, fs_d, bl_s, hs_s, vs_s, fs_s, bl_t, hs_t, vs_t, fs_t;
  logic [15:0] fc_d, fc_s, fc_t;

  vga_timing_gen u_def (
    .vga_clk(clk), .reset_n(rst_def), .DrawX(dx_d), .DrawY(dy_d), .blank(bl_d),
    .hs(hs_d), .vs(vs_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
  ) u_small (
    .vga_clk(clk), .reset_n(rst_s), .DrawX(dx_s), .DrawY(dy_s), .blank(bl_s),
    .hs(hs_s), .vs(vs_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  vga_timing_gen #(
    .H_VISIBLE(1), .H_FRONT(0), .H_SYNC(0), .H_BACK(0),
    .V_VISIBLE(1), .V_FRONT(0), .V_SYNC(0), .V_BACK(0), .SYNC_POL(1'b0)
  ) u_tiny (
    .vga_clk(clk), .reset_n(rst_t), .DrawX(dx_t), .DrawY(dy_t), .blank(bl_t),
    .hs(hs_t), .vs(vs_t), .frame_start(fs_t), .frame_count(fc_t)
  );

  initial forever #5 clk = ~clk;

  function automatic int ht(timing_t c);
    return c.hv + c.hf + c.hsw + c.hb;
  endfunction

  function automatic int ft(timing_t c);
    return ht(c) * (c.vv + c.vf + c.vsw + c.vb);
  endfunction

  // t = clock edges since reset release; t = 0 is the reset state itself
  function automatic bit hs_on(timing_t c, int t);
    int x;
    x = (t % ft(c)) % ht(c);
    return t > 0 && x >= c.hv + c.hf && x < c.hv + c.hf + c.hsw;
  endfunction

  function automatic bit vs_on(timing_t c, int t);
    int y;
    y = (t % ft(c)) / ht(c);
    return t > 0 && y >= c.vv + c.vf && y < c.vv + c.vf + c.vsw;
  endfunction

  function automatic exp_t model(timing_t c, int t);
    exp_t e;
    int p;
    p    = t % ft(c);
    e.x  = p % ht(c);
    e.y  = p / ht(c);
    e.b  = t > 0 && e.x < c.hv && e.y < c.vv;
    e.hs = (t >= D && hs_on(c, t - D)) ? c.pol : !c.pol;
    e.vs = (t >= D && vs_on(c, t - D)) ? c.pol : !c.pol;
    e.fs = t >= 1 + D && (t - D) % ft(c) == 0;
    e.fc = (t / ft(c)) % 65536;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_inst(string tag, timing_t c, int t, logic [9:0] x, logic [9:0] y,
                          logic b, logic h, logic v, logic f, logic [15:0] fc);
    exp_t e;
    e = model(c, t);
    chk({tag, ".DrawX"}, 32'(x), 32'(e.x));
    chk({tag, ".DrawY"}, 32'(y), 32'(e.y));
    chk({tag, ".blank"}, 32'(b), 32'(e.b));
    chk({tag, ".hs"}, 32'(h), 32'(e.hs));
    chk({tag, ".vs"}, 32'(v), 32'(e.vs));
    chk({tag, ".frame_start"}, 32'(f), 32'(e.fs));
    chk({tag, ".frame_count"}, 32'(fc), 32'(e.fc));
  endtask

  task automatic chk_def(string tag);
    chk_inst(tag, c_def, t_def, dx_d, dy_d, bl_d, hs_d, vs_d, fs_d, fc_d);
  endtask

  task automatic chk_small(string tag);
    chk_inst(tag, c_small, t_s, dx_s, dy_s, bl_s, hs_s, vs_s, fs_s, fc_s);
  endtask

  task automatic chk_tiny(string tag);
    chk_inst(tag, c_tiny, t_t, dx_t, dy_t, bl_t, hs_t, vs_t, fs_t, fc_t);
  endtask

  // advance to the next falling edge, counting the rising edge seen out of reset
  task automatic step();
    @(negedge clk);
    if (rst_def) t_def++;
    if (rst_s) t_s++;
    if (rst_t) t_t++;
  endtask

  initial begin
    int n, off;
    repeat (10) step();
    chk_def("rst_def");
    chk_small("rst_small");
    chk_tiny("rst_tiny");
    rst_def = 1'b1;
    rst_s   = 1'b1;
    rst_t   = 1'b1;
    while (t_def < 1100) begin
      step();
      chk_def("run_def");
      chk_small("run_small");
      chk_tiny("run_tiny");
    end
    #2 rst_def = 1'b0;
    t_def = 0;
    #1 chk_def("async_def");
    step();
    chk_def("hold_def");
    rst_def = 1'b1;
    repeat (900) begin
      step();
      chk_def("restart_def");
    end
    repeat (8) begin
      n = $urandom_range(1, 120);
      repeat (n) begin
        step();
        chk_small("rand_small");
      end
      off = $urandom_range(1, 3);
      #(off) rst_s = 1'b0;
      t_s = 0;
      #1 chk_small("async_small");
      n = $urandom_range(1, 3);
      repeat (n) begin
        step();
        chk_small("hold_small");
      end
      rst_s = 1'b1;
    end
    repeat (80) begin
      step();
      chk_small("tail_small");
    end
    while (t_t < 65534) step();
    repeat (5) begin
      step();
      chk_tiny("wrap_tiny");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
